// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port RAM between instruction fetch and load/store.
// Define MEM_ARB_STARVE_GUARD_EN to bound how long fetch can be starved by data traffic.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_write,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [1:0]            d_size,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [1:0]            ram_size,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {FETCH, DATA} owner_t;

  state_t state;
  owner_t owner;
  logic   owner_store;
  logic   pick_data;
  logic   pick_fetch;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_cnt;

  // Once fetch has watched LIMIT data grants go by, it takes the next contested slot.
  assign pick_data = d_req && !(if_req && (starve_cnt == LIMIT));
`else
  logic unused_limit;
  assign unused_limit = ^STARVE_LIMIT;
  assign pick_data    = d_req;
`endif
  assign pick_fetch = if_req && !pick_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= FETCH;
      owner_store <= 1'b0;
      if_gnt      <= 1'b0;
      d_gnt       <= 1'b0;
      if_rvalid   <= 1'b0;
      d_rvalid    <= 1'b0;
      ram_addr    <= '0;
      ram_write   <= 1'b0;
      ram_wdata   <= '0;
      ram_size    <= 2'b00;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_cnt  <= '0;
`endif
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      ram_write <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (pick_data) begin
            state       <= ISSUE;
            owner       <= DATA;
            owner_store <= d_write;
            d_gnt       <= 1'b1;
            ram_addr    <= d_addr;
            ram_write   <= d_write;
            ram_wdata   <= d_wdata;
            ram_size    <= d_size;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_cnt  <= if_req ? starve_cnt + 1'b1 : '0;
`endif
          end else if (pick_fetch) begin
            state       <= ISSUE;
            owner       <= FETCH;
            owner_store <= 1'b0;
            if_gnt      <= 1'b1;
            ram_addr    <= if_addr;
            ram_size    <= 2'b10;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_cnt  <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          // RAM samples the address at this edge; its data is valid during RESP.
          state <= RESP;
          if (!owner_store) begin
            if (owner == DATA) d_rvalid  <= 1'b1;
            else               if_rvalid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign if_rdata = if_rvalid ? ram_rdata : '0;
  assign d_rdata  = d_rvalid  ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioral RAM, reference memory and a response scoreboard.
module tb_mem_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req, d_req, d_write;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [1:0]    d_size;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, ram_write;
  logic [DW-1:0] if_rdata, d_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [1:0]    ram_size;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_write(ram_write), .ram_wdata(ram_wdata), .ram_size(ram_size),
    .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a == 14'h0004) ? 32'hE3A01005 : (32'hA500_0000 | (32'(a) * 32'd3));
  endfunction

  // Behavioral RAM: synchronous read, data one cycle after the address.
  logic [DW-1:0] mem [16384];
  bit            written [16384];
  always @(posedge clock) begin
    if (ram_write) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_word(ram_addr);
  end

  // Reference memory and scoreboard.
  logic [DW-1:0] ref_st [int];
  typedef struct packed { logic is_data; logic [DW-1:0] data; } resp_t;
  resp_t exp_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int wr_cycles = 0;
  int drv_cnt = 0;
  int gnt_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_st.exists(int'(a)) ? ref_st[int'(a)] : init_word(a);
  endfunction

  always @(negedge clock) begin
    wr_cycles += int'(ram_write);
    drv_cnt   += int'(d_rvalid);
    gnt_total += int'(if_gnt) + int'(d_gnt);
    if (if_rvalid || d_rvalid) begin
      check("single_rvalid", {63'd0, if_rvalid & d_rvalid}, 64'd0);
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'd1, 64'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_src", {63'd0, d_rvalid}, {63'd0, e.is_data});
        check("resp_data", 64'(d_rvalid ? d_rdata : if_rdata), 64'(e.data));
      end
    end else begin
      check("rdata_idle_zero", {if_rdata, d_rdata}, 64'd0);
    end
  end

  // One request, waits (bounded) for its grant and checks the response cycle; returns cycles waited.
  task automatic access(input bit is_data, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output int waited);
    bit got = 0;
    waited = 0;
    if (is_data) begin
      d_req = 1; d_addr = addr; d_write = wr; d_wdata = wd; d_size = 2'b10;
      if (wr) ref_st[int'(addr)] = wd;
      else exp_q.push_back({1'b1, ref_read(addr)});
    end else begin
      if_req = 1; if_addr = addr;
      exp_q.push_back({1'b0, ref_read(addr)});
    end
    while (!got && waited < 10) begin
      @(posedge clock); #1;
      waited++;
      got = is_data ? d_gnt : if_gnt;
    end
    check("gnt_seen", {63'd0, got}, 64'd1);
    check("ram_addr", 64'(ram_addr), 64'(addr));
    check("ram_write_issue", {63'd0, ram_write}, {63'd0, is_data & wr});
    check("ram_size", 64'(ram_size), 64'd2);
    if_req = 0; d_req = 0; d_write = 0;
    @(posedge clock); #1;
    check("rvalid_latency", {63'd0, is_data ? d_rvalid : if_rvalid}, {63'd0, !wr});
    check("ram_write_resp", {63'd0, ram_write}, 64'd0);
  endtask

  initial begin
    int w, wr0, dr0, g0, dc, ic, dn, fn, dn_at_f, cyc;
    reset = 1; if_req = 0; d_req = 0; d_write = 0; if_addr = '0; d_addr = '0;
    d_wdata = '0; d_size = 2'b00;

    // Reset held for two cycles.
    repeat (2) @(posedge clock);
    #1;
    check("rst_outputs", {if_gnt, if_rvalid, d_gnt, d_rvalid, ram_write, ram_size}, 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    reset = 0;
    @(posedge clock); #1;

    // Fetch one cycle after reset release.
    access(0, 0, 14'h0004, '0, w);
    check("fetch_gnt_wait", 64'(w), 64'd1);

    // Store then load back.
    wr0 = wr_cycles; dr0 = drv_cnt;
    access(1, 1, 14'h0010, 32'hDEADBEEF, w);
    repeat (3) @(posedge clock);
    #1;
    check("store_write_cycles", 64'(wr_cycles - wr0), 64'd1);
    check("store_no_rvalid", 64'(drv_cnt - dr0), 64'd0);
    access(1, 0, 14'h0010, '0, w);
    check("load_gnt_wait", 64'(w), 64'd1);
    access(1, 0, 14'h0123, '0, w);

    // Contention: data first, fetch two cycles later (back-to-back).
    exp_q.push_back({1'b1, ref_read(14'h0200)});
    exp_q.push_back({1'b0, ref_read(14'h0300)});
    d_req = 1; d_addr = 14'h0200; d_write = 0; d_size = 2'b10;
    if_req = 1; if_addr = 14'h0300;
    dc = -1; ic = -1; cyc = 0;
    while ((dc < 0 || ic < 0) && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
      if (d_gnt && dc < 0) begin dc = cyc; d_req = 0; end
      if (if_gnt && ic < 0) begin ic = cyc; if_req = 0; end
    end
    check("cont_d_first", 64'(dc), 64'd1);
    check("cont_if_gap", 64'(ic - dc), 64'd2);
    repeat (3) @(posedge clock);

    // Starvation: data held for 12 loads while fetch waits.
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, ref_read(14'(14'h0400 + k))});
    exp_q.push_back({1'b0, ref_read(14'h0008)});
    for (int k = 4; k < 12; k++) exp_q.push_back({1'b1, ref_read(14'(14'h0400 + k))});
`else
    for (int k = 0; k < 12; k++) exp_q.push_back({1'b1, ref_read(14'(14'h0400 + k))});
    exp_q.push_back({1'b0, ref_read(14'h0008)});
`endif
    #1;
    if_req = 1; if_addr = 14'h0008;
    d_req = 1; d_addr = 14'h0400; d_write = 0; d_size = 2'b10;
    dn = 0; fn = 0; dn_at_f = -1; cyc = 0;
    while (!(dn == 12 && fn == 1) && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
      if (d_gnt) begin
        dn++;
        if (dn == 12) d_req = 0;
        else d_addr = 14'(14'h0400 + dn);
      end
      if (if_gnt) begin fn++; dn_at_f = dn; if_req = 0; end
    end
    check("starve_done", {63'd0, dn == 12 && fn == 1}, 64'd1);
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("starve_guard_fetch_after", 64'(dn_at_f), 64'd4);
`else
    check("starve_strict_fetch_after", 64'(dn_at_f), 64'd12);
`endif
    d_req = 0; if_req = 0;
    repeat (3) @(posedge clock);

    // Reset during ISSUE of a load: no response, no grant without a new request.
    #1;
    d_req = 1; d_addr = 14'h0020; d_write = 0; d_size = 2'b10;
    cyc = 0;
    while (!d_gnt && cyc < 10) begin @(posedge clock); #1; cyc++; end
    check("rstmid_gnt", {63'd0, d_gnt}, 64'd1);
    reset = 1; d_req = 0;
    @(posedge clock); #1;
    check("rstmid_outputs", {if_gnt, if_rvalid, d_gnt, d_rvalid, ram_write, ram_size}, 64'd0);
    check("rstmid_ram_addr", 64'(ram_addr), 64'd0);
    @(posedge clock); #1;
    reset = 0;
    g0 = gnt_total; dr0 = drv_cnt;
    repeat (4) @(posedge clock);
    #1;
    check("rstmid_no_gnt", 64'(gnt_total - g0), 64'd0);
    check("rstmid_no_rvalid", 64'(drv_cnt - dr0), 64'd0);
    access(0, 0, 14'h0004, '0, w);
    check("post_rst_gnt_wait", 64'(w), 64'd1);

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin @(posedge clock); cyc++; end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the CPU's single-port `ram` between the instruction-fetch requester (IF stage) and the load/store requester (MEM stage). It accepts one request per arbitration point, drives the RAM port, and returns read data to the winning requester with a fixed latency. It sits between the pipeline stages in `control_unit` and the `ram` instance, replacing the direct `in_Addr <= pc` connection.

## Interface
Parameters:
- `ADDR_WIDTH`, 14: RAM address width.
- `DATA_WIDTH`, 32: word width; matches `` `WordWidth``.
- `STARVE_LIMIT`, 4: maximum consecutive data grants while fetch waits. Used only with `MEM_ARB_STARVE_GUARD_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDR_WIDTH  fetch address
- `if_gnt`  out  1  fetch granted (one-cycle pulse)
- `if_rvalid`  out  1  fetch data valid (one-cycle pulse)
- `if_rdata`  out  DATA_WIDTH  fetch data
- `d_req`  in  1  load/store request
- `d_addr`  in  ADDR_WIDTH  data address
- `d_write`  in  1  1 = store, 0 = load
- `d_wdata`  in  DATA_WIDTH  store data
- `d_size`  in  2  access size (2'b10 = word)
- `d_gnt`  out  1  data granted (one-cycle pulse)
- `d_rvalid`  out  1  load data valid (one-cycle pulse)
- `d_rdata`  out  DATA_WIDTH  load data
- `ram_addr`  out  ADDR_WIDTH  to `ram` address
- `ram_write`  out  1  to `ram` write enable
- `ram_wdata`  out  DATA_WIDTH  to `ram` write data
- `ram_size`  out  2  to `ram` size
- `ram_rdata`  in  DATA_WIDTH  from `ram`; valid one cycle after the address is presented

## Operation
- The FSM has three states: IDLE, ISSUE and RESP. Owner register: FETCH or DATA.
- Arbitration happens only on the edge leaving IDLE or RESP. Requests seen during ISSUE are ignored.
- Priority: `d_req` beats `if_req`. This keeps the MEM stage from stalling behind IF.
- On a win (IDLE/RESP → ISSUE):
  - Register `ram_addr` from the winner.
  - For DATA, also register `ram_write`, `ram_wdata` and `ram_size`.
  - For FETCH, `ram_write`=0 and `ram_size`=2'b10.
- ISSUE:
  - The winner's `*_gnt`=1 for exactly this cycle.
  - `ram_write` is high only here, and only for a store.
  - Next state is RESP.
- RESP:
  - For a load or fetch, the owner's `*_rvalid`=1 and `*_rdata`=`ram_rdata` (combinational pass-through).
  - For a store, both `*_rvalid` stay 0.
  - Next state is ISSUE if any request is pending, else IDLE.
- Outside RESP, `if_rdata` and `d_rdata` are 0.
- Requester rule: hold `req`, address and data stable until the `gnt` cycle. Drop `req` or change the request after `gnt`.
- Addresses are forwarded unmodified. There is no alignment check.
- Reset (any state, including mid-access):
  - Next state is IDLE.
  - All outputs go to 0.
  - Owner = FETCH, starvation counter = 0.
  - A pending `rvalid` is suppressed.
  - `ram_write` is 0 in the cycle after reset.

## Timing
- Request seen at edge E0 → `gnt` high in the cycle after E0 (ISSUE).
- RAM captures the address at E1 → `rvalid` high in the cycle after E1.
- Read latency: 2 cycles from the sampling edge.
- Throughput: one access every 2 cycles (RESP → ISSUE back-to-back).
- `ram_*` outputs are registered. `*_rdata` is combinational from `ram_rdata`.
- Both requesting at the same arbitration edge: DATA wins and FETCH stays pending. FETCH is granted at the next arbitration edge if `d_req` is low then.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A counter increments on each DATA grant made while `if_req`=1.
  - It clears on any FETCH grant, or on a DATA grant with `if_req`=0.
  - When the counter equals `STARVE_LIMIT` and both request, FETCH wins.
- Undefined: strict DATA priority. There is no counter, and FETCH can starve indefinitely.

## Test plan
- Reset: assert `reset` 2 cycles → all outputs 0, `ram_write`=0, FSM idle. A request arriving 1 cycle after reset release is granted normally.
- Fetch only: RAM[0x0004]=0xE3A01005, `if_req`=1, `if_addr`=0x0004 → `if_gnt` in the next cycle, then `if_rvalid`=1 with `if_rdata`=0xE3A01005 in the following cycle.
- Store/load: `d_write`=1, `d_addr`=0x0010, `d_wdata`=0xDEADBEEF, `d_size`=2'b10 → `ram_write` high for exactly one cycle and `d_rvalid` never asserted. A subsequent load from 0x0010 → `d_rdata`=0xDEADBEEF.
- Contention: `if_req` and `d_req` rise together → `d_gnt` first, then `if_gnt` two cycles later. Check that back-to-back RESP→ISSUE inserts no idle cycle.
- Starvation: `d_req` held high for 12 accesses with `if_req` high.
  - With `MEM_ARB_STARVE_GUARD_EN`: `if_gnt` after exactly 4 `d_gnt` pulses.
  - Without it: zero `if_gnt`.
- Reset mid-access: assert `reset` during ISSUE of a load → no `d_rvalid` follows, and the next grant occurs only after a fresh request.
